uart_receive: RTL and testbench
===============================

UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter REGISTER_SIZE, default 1024: width of the assembled register in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter CLK_BAUD_RATIO, default 8: clk_in cycles per serial bit; SHALL be at least 4.
REQ-003 clk_in  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 rx_in  input  1  serial line, asynchronous to clk_in, idle high.
REQ-006 register_out  output  REGISTER_SIZE  last completely received register.
REQ-007 valid_out  output  1  one-cycle pulse when register_out is updated.
REQ-008 busy_out  output  1  high while a frame is in progress or a register is partially filled.
REQ-009 frame_error_out  output  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB-first, one stop bit (1).
REQ-012 States SHALL be IDLE, START, DATA and STOP.
REQ-013 IDLE->START SHALL occur on a 1->0 transition of rx_s (t0); the bit-phase counter SHALL reset at t0.
REQ-014 In START, rx_s SHALL be sampled at t0+CLK_BAUD_RATIO/2 (integer division); if rx_s=1, the block SHALL return to IDLE with no state change (glitch rejection).
REQ-015 Data bit i (0..7) SHALL be sampled at t0+CLK_BAUD_RATIO/2+(i+1)*CLK_BAUD_RATIO.
REQ-016 The stop bit SHALL be sampled at t0+CLK_BAUD_RATIO/2+9*CLK_BAUD_RATIO, and the block SHALL then return to IDLE.
REQ-017 A valid byte (stop=1) SHALL be written to bits [8k+7:8k] of an internal shift buffer, where k is the byte index, starting at 0.
REQ-018 Stop=0 SHALL pulse frame_error_out for one cycle, discard the byte, and leave k unchanged.
REQ-019 When byte k=REGISTER_SIZE/8-1 is accepted, the full buffer SHALL be copied to register_out, valid_out SHALL pulse on the next cycle, and k SHALL wrap to 0.
REQ-020 register_out SHALL hold its value between valid_out pulses; partial fills SHALL never be visible on it.
REQ-021 busy_out SHALL be high when state!=IDLE or k!=0; otherwise low.
REQ-022 A falling edge on rx_s in any state other than IDLE SHALL be ignored.
REQ-023 The byte-index counter SHALL be $clog2(REGISTER_SIZE/8) bits wide, minimum 1; the phase counter SHALL be $clog2(CLK_BAUD_RATIO)+1 bits wide.

Reset
REQ-024 On rst_in: state=IDLE, k=0, counters=0, synchronizer flops=1, register_out=0, valid_out=0, busy_out=0, frame_error_out=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and discard the partial register with no valid_out; reset SHALL take priority over all other events.

Structure
REQ-026 State enum (IDLE/START/DATA/STOP) and the constants FRAME_DATA_BITS=8 and STOP_LEVEL=1 SHALL live in a shared package, uart_pkg, which the matching transmitter also uses.
REQ-027 One sub-module SHALL be used: sync_2ff, the 2-flop synchronizer (reset value parameterized).

Verification (REGISTER_SIZE=16, CLK_BAUD_RATIO=8 unless noted)
REQ-028 Send bytes 0xA5 then 0x3C -> one valid_out pulse with register_out=16'h3CA5; busy_out high from the first start bit until valid_out.
REQ-029 rx_in low for 2 cycles in IDLE -> no state advance past START, busy_out returns to 0, no pulses.
REQ-030 Byte 0x11 with stop=0, then 0x22, 0x33 -> frame_error_out pulses once; register_out=16'h3322.
REQ-031 rst_in asserted during bit 4 of byte 1 (first byte 0x55 already accepted), then bytes 0x01, 0x02 -> register_out=16'h0201 and exactly one valid_out.
REQ-032 Three registers back-to-back with no idle gap (6 frames) -> three valid_out pulses with correct data; k wraps each time.
REQ-033 CLK_BAUD_RATIO=5 with sampling-point check, and REGISTER_SIZE=8 -> single-byte registers, valid_out after every byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
package uart_pkg;

  // Frame progress: waiting for a start edge, qualifying the start bit,
  // shifting data bits, checking the stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic STOP_LEVEL      = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  // First stage may go metastable; the second stage gives it a cycle to settle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stage_reg <= {2{RESET_VALUE}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver that packs consecutive bytes (LSB byte first) into a
// wide register and publishes it only once every byte lane has been filled.
module uart_receive
  import uart_pkg::*;
#(
  parameter int REGISTER_SIZE  = 1024,
  parameter int CLK_BAUD_RATIO = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rx_in,
  output logic [REGISTER_SIZE-1:0] register_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic                     frame_error_out
);

  localparam int NUM_BYTES = REGISTER_SIZE / FRAME_DATA_BITS;
  localparam int K_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int PHASE_W   = $clog2(CLK_BAUD_RATIO) + 1;
  localparam int BIT_W     = $clog2(FRAME_DATA_BITS);

  // The phase counter restarts at 0 on the cycle after each reference point,
  // so a sample lands when it reaches (distance - 1).
  localparam logic [PHASE_W-1:0] HALF_SAMPLE = PHASE_W'(CLK_BAUD_RATIO / 2 - 1);
  localparam logic [PHASE_W-1:0] FULL_SAMPLE = PHASE_W'(CLK_BAUD_RATIO - 1);
  localparam logic [K_W-1:0]     LAST_K      = K_W'(NUM_BYTES - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT    = BIT_W'(FRAME_DATA_BITS - 1);

  logic                       rx_s;
  logic                       rx_prev_reg;
  uart_state_t                state_reg;
  logic [PHASE_W-1:0]         phase_reg;
  logic [BIT_W-1:0]           bit_reg;
  logic [K_W-1:0]             k_reg;
  logic [FRAME_DATA_BITS-1:0] shift_reg;
  logic [REGISTER_SIZE-1:0]   buf_reg;
  logic [REGISTER_SIZE-1:0]   buf_next;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (rx_in),
    .q      (rx_s)
  );

  // Buffer contents as they would be with the current byte dropped into lane k.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign buf_next[FRAME_DATA_BITS*gi +: FRAME_DATA_BITS] =
        (k_reg == K_W'(gi)) ? shift_reg : buf_reg[FRAME_DATA_BITS*gi +: FRAME_DATA_BITS];
    end
  endgenerate

  // Frame FSM: start-edge detect, mid-bit sampling, byte packing and publish.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_prev_reg     <= 1'b1;
      state_reg       <= IDLE;
      phase_reg       <= '0;
      bit_reg         <= '0;
      k_reg           <= '0;
      shift_reg       <= '0;
      buf_reg         <= '0;
      register_out    <= '0;
      valid_out       <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      rx_prev_reg     <= rx_s;
      valid_out       <= 1'b0;
      frame_error_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          phase_reg <= '0;
          if (rx_prev_reg && !rx_s) begin
            state_reg <= START;
          end
        end
        START: begin
          if (phase_reg == HALF_SAMPLE) begin
            phase_reg <= '0;
            bit_reg   <= '0;
            // A line already back high mid start-bit is treated as noise.
            state_reg <= rx_s ? IDLE : DATA;
          end else begin
            phase_reg <= phase_reg + PHASE_W'(1);
          end
        end
        DATA: begin
          if (phase_reg == FULL_SAMPLE) begin
            phase_reg <= '0;
            shift_reg <= {rx_s, shift_reg[FRAME_DATA_BITS-1:1]};
            bit_reg   <= bit_reg + BIT_W'(1);
            if (bit_reg == LAST_BIT) begin
              state_reg <= STOP;
            end
          end else begin
            phase_reg <= phase_reg + PHASE_W'(1);
          end
        end
        STOP: begin
          if (phase_reg == FULL_SAMPLE) begin
            phase_reg <= '0;
            state_reg <= IDLE;
            if (rx_s == STOP_LEVEL) begin
              buf_reg <= buf_next;
              if (k_reg == LAST_K) begin
                register_out <= buf_next;
                valid_out    <= 1'b1;
                k_reg        <= '0;
              end else begin
                k_reg <= k_reg + K_W'(1);
              end
            end else begin
              frame_error_out <= 1'b1;
            end
          end else begin
            phase_reg <= phase_reg + PHASE_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Busy covers both an in-flight frame and a partially filled register.
  assign busy_out = (state_reg != IDLE) || (k_reg != '0);

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: a 16-bit/8-ratio instance and an 8-bit/5-ratio
// instance, driven by directed and random 8N1 frames and scored against a
// byte-level model of what each instance should publish.
module tb_uart_receive;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in = 1'b1;
  logic        rx_a   = 1'b1;
  logic        rx_b   = 1'b1;
  logic [15:0] reg_a;
  logic        valid_a, busy_a, fe_a;
  logic [7:0]  reg_b;
  logic        valid_b, busy_b, fe_b;

  uart_receive #(.REGISTER_SIZE(16), .CLK_BAUD_RATIO(8)) dut_a (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rx_in           (rx_a),
    .register_out    (reg_a),
    .valid_out       (valid_a),
    .busy_out        (busy_a),
    .frame_error_out (fe_a)
  );

  uart_receive #(.REGISTER_SIZE(8), .CLK_BAUD_RATIO(5)) dut_b (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rx_in           (rx_b),
    .register_out    (reg_b),
    .valid_out       (valid_b),
    .busy_out        (busy_b),
    .frame_error_out (fe_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observed behaviour, collected on the falling edge.
  logic [15:0] got_a[$];
  logic [7:0]  got_b[$];
  int          fe_cnt_a = 0, fe_cnt_b = 0;
  int          hold_err_a = 0, hold_err_b = 0;
  logic [15:0] prev_a = '0;
  logic [7:0]  prev_b = '0;

  always @(negedge clk_in) begin
    if (valid_a) got_a.push_back(reg_a);
    if (valid_b) got_b.push_back(reg_b);
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if (!rst_in && !valid_a && reg_a !== prev_a) hold_err_a++;
    if (!rst_in && !valid_b && reg_b !== prev_b) hold_err_b++;
    prev_a = reg_a;
    prev_b = reg_b;
  end

  // Reference model: bytes with a good stop bit accumulate; a full set of
  // bytes becomes one expected register, first byte in the low lane.
  logic [15:0] exp_a[$];
  logic [7:0]  exp_b[$];
  logic [7:0]  part_a[$];
  int          exp_fe_a = 0, exp_fe_b = 0;
  logic [15:0] last_exp_a = '0;
  logic [7:0]  last_exp_b = '0;

  task automatic model_byte(input int which, input logic [7:0] data, input logic stop);
    if (which == 0) begin
      if (!stop) exp_fe_a++;
      else begin
        part_a.push_back(data);
        if (part_a.size() == 2) begin
          last_exp_a = {part_a[1], part_a[0]};
          exp_a.push_back(last_exp_a);
          part_a.delete();
        end
      end
    end else begin
      if (!stop) exp_fe_b++;
      else begin
        last_exp_b = data;
        exp_b.push_back(data);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic idle(input int n);
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Sends the first nbits bit-periods of a frame. In strict mode each bit
  // holds its true level only at the nominal mid-bit sample offset and the
  // inverse elsewhere (the start edge and the stop-bit tail stay true so that
  // frame boundaries are unaffected), so any sampling-point error corrupts data.
  task automatic send_bits(input int which, input logic [7:0] data, input logic stop,
                           input bit strict, input int nbits);
    int   n;
    int   h;
    logic v;
    logic d;
    n = (which == 0) ? 8 : 5;
    h = n / 2;
    for (int j = 0; j < nbits; j++) begin
      if (j == 0) v = 1'b0;
      else if (j == 9) v = stop;
      else v = data[j-1];
      for (int o = 0; o < n; o++) begin
        d = v;
        if (strict && o != h && !(j == 0 && o == 0) && !(j == 9 && o > h)) d = ~v;
        drive(which, d);
        @(posedge clk_in);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic stop, input bit strict);
    send_bits(which, data, stop, strict, 10);
    model_byte(which, data, stop);
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_a_count"}, 32'(got_a.size()), 32'(exp_a.size()));
    while (got_a.size() > 0 && exp_a.size() > 0)
      chk({tag, "_a_data"}, 32'(got_a.pop_front()), 32'(exp_a.pop_front()));
    got_a.delete();
    exp_a.delete();
    chk({tag, "_a_ferr"}, 32'(fe_cnt_a), 32'(exp_fe_a));
    chk({tag, "_a_hold"}, 32'(hold_err_a), 32'(0));
    chk({tag, "_a_busy"}, 32'(busy_a), 32'(part_a.size() != 0));
    chk({tag, "_a_reg"}, 32'(reg_a), 32'(last_exp_a));
  endtask

  task automatic check_b(input string tag);
    chk({tag, "_b_count"}, 32'(got_b.size()), 32'(exp_b.size()));
    while (got_b.size() > 0 && exp_b.size() > 0)
      chk({tag, "_b_data"}, 32'(got_b.pop_front()), 32'(exp_b.pop_front()));
    got_b.delete();
    exp_b.delete();
    chk({tag, "_b_ferr"}, 32'(fe_cnt_b), 32'(exp_fe_b));
    chk({tag, "_b_hold"}, 32'(hold_err_b), 32'(0));
    chk({tag, "_b_busy"}, 32'(busy_b), 32'(0));
    chk({tag, "_b_reg"}, 32'(reg_b), 32'(last_exp_b));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    bit         st;
    int         gap;

    // Reset state.
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_a_reg", 32'(reg_a), 32'(0));
    chk("rst_a_valid", 32'(valid_a), 32'(0));
    chk("rst_a_busy", 32'(busy_a), 32'(0));
    chk("rst_a_ferr", 32'(fe_a), 32'(0));
    chk("rst_b_reg", 32'(reg_b), 32'(0));
    chk("rst_b_busy", 32'(busy_b), 32'(0));
    rst_in = 1'b0;
    idle(4);

    // Two bytes form one register; busy holds across the gap between them.
    send_frame(0, 8'hA5, 1'b1, 1'b0);
    idle(4);
    chk("pair_busy_mid", 32'(busy_a), 32'(1));
    send_frame(0, 8'h3C, 1'b1, 1'b0);
    idle(10);
    check_a("pair");
    $display("pair: register_out=%h", reg_a);

    // Short low glitch in IDLE on both lines.
    drive(0, 1'b0);
    drive(1, 1'b0);
    repeat (2) begin @(posedge clk_in); #1; end
    idle(2);
    chk("glitch_a_busy_start", 32'(busy_a), 32'(1));
    chk("glitch_b_busy_start", 32'(busy_b), 32'(1));
    idle(12);
    check_a("glitch");
    check_b("glitch");
    $display("glitch: busy_a=%0d busy_b=%0d", busy_a, busy_b);

    // Framing error discards the byte and leaves the lane index alone.
    send_frame(0, 8'h11, 1'b0, 1'b0);
    idle(3);
    send_frame(0, 8'h22, 1'b1, 1'b0);
    send_frame(0, 8'h33, 1'b1, 1'b0);
    idle(10);
    check_a("ferr");
    $display("ferr: register_out=%h errors=%0d", reg_a, fe_cnt_a);

    // Reset during bit 4 of the second byte.
    send_frame(0, 8'h55, 1'b1, 1'b0);
    send_bits(0, 8'hAA, 1'b1, 1'b0, 5);
    repeat (3) begin @(posedge clk_in); #1; end
    rst_in = 1'b1;
    repeat (2) begin @(posedge clk_in); #1; end
    rst_in = 1'b0;
    part_a.delete();
    last_exp_a = '0;
    last_exp_b = '0;
    idle(4);
    chk("midrst_reg", 32'(reg_a), 32'(0));
    chk("midrst_busy", 32'(busy_a), 32'(0));
    send_frame(0, 8'h01, 1'b1, 1'b0);
    send_frame(0, 8'h02, 1'b1, 1'b0);
    idle(10);
    check_a("midrst");
    $display("midrst: register_out=%h", reg_a);

    // Three registers back-to-back, strictly timed.
    for (int i = 0; i < 6; i++) send_frame(0, 8'($urandom), 1'b1, 1'b1);
    idle(10);
    check_a("b2b");
    $display("b2b: last register_out=%h", reg_a);

    // Ratio 5, single-byte registers, strict sampling windows.
    for (int i = 0; i < 6; i++) send_frame(1, 8'($urandom), 1'b1, 1'b1);
    idle(10);
    check_b("ratio5");
    $display("ratio5: last register_out=%h", reg_b);

    // Random mix on both instances: errors, gaps, strict timing.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 12; i++) begin
        rb  = 8'($urandom);
        rs  = ($urandom_range(0, 4) != 0);
        st  = rs && ($urandom_range(0, 1) == 1);
        gap = $urandom_range(0, 2);
        if (!rs && gap < 2) gap = 2;
        send_frame(w, rb, rs, st);
        if (gap > 0) idle(gap);
        $display("rand: dut=%0d byte=%h stop=%0d strict=%0d gap=%0d", w, rb, rs, st, gap);
      end
      idle(12);
    end
    check_a("rand");
    check_b("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
